// File: rtl/fft_pitch_detector_if.sv
// Valid/ready stream carrying the detected pitch bin index from the detector to its sink.
interface fft_pitch_detector_if #(
  parameter int unsigned N = 10
) ();
  logic [N-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fft_pitch_detector.sv
// Consumes one FFT output frame, finds the strongest bin in 1..NSamples/2-1 by |X|^2 and
// publishes its index on a valid/ready stream; partial frames are discarded with an abort pulse.
module fft_pitch_detector #(
  parameter int unsigned W         = 16,
  parameter int unsigned NSamples  = 1024,
  parameter logic [2*W:0] THRESHOLD = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [W-1:0]         fft_output_re,
  input  logic signed [W-1:0]         fft_output_im,
  input  logic                        fft_output_valid,
  fft_pitch_detector_if.master        pitch_output,
  output logic                        overflow,
  output logic                        abort
);

  localparam int unsigned Log  = $clog2(NSamples);
  localparam int unsigned MagW = 2 * W + 1;

  logic [Log-1:0]    cnt_q, cnt_d;
  logic              s1_valid_q, s1_last_q, s1_abort_q;
  logic [Log-1:0]    s1_idx_q;
  logic [2*W-1:0]    s1_rr_q, s1_ii_q, s1_rr_d, s1_ii_d;
  logic              s2_valid_q, s2_last_q, s2_abort_q;
  logic [Log-1:0]    s2_idx_q;
  logic [MagW-1:0]   s2_mag_q, s2_mag_d;
  logic              s3_last_q;
  logic [MagW-1:0]   max_q, max_d;
  logic [Log-1:0]    max_idx_q, max_idx_d;
  logic [Log-1:0]    data_q, data_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;
  logic              abort_q;
  logic signed [2*W-1:0] re_x, im_x;
  logic              in_half, below_thr;

  always_comb begin
    cnt_d = fft_output_valid ? cnt_q + Log'(1) : '0;
    re_x  = {{W{fft_output_re[W-1]}}, fft_output_re};
    im_x  = {{W{fft_output_im[W-1]}}, fft_output_im};
    s1_rr_d  = re_x * re_x;
    s1_ii_d  = im_x * im_x;
    s2_mag_d = {1'b0, s1_rr_q} + {1'b0, s1_ii_q};
  end

  // Running peak; the end-of-frame and abort clears land on edges where only a next-frame
  // bin 0 (always ignored) can be in the compare stage.
  always_comb begin
    max_d     = max_q;
    max_idx_d = max_idx_q;
    in_half   = (s2_idx_q != '0) && !s2_idx_q[Log-1];
    if (s3_last_q || s2_abort_q) begin
      max_d     = '0;
      max_idx_d = '0;
    end else if (s2_valid_q && in_half && (s2_mag_q > max_q)) begin
      max_d     = s2_mag_q;
      max_idx_d = s2_idx_q;
    end
  end

  always_comb begin
    // Leading 1 on both sides keeps the compare non-constant when THRESHOLD is zero.
    below_thr  = {1'b1, max_q} < {1'b1, THRESHOLD};
    data_d     = data_q;
    valid_d    = valid_q;
    overflow_d = 1'b0;
    if (s3_last_q) begin
      data_d     = below_thr ? '0 : max_idx_q;
      valid_d    = 1'b1;
      overflow_d = valid_q && !pitch_output.ready;
    end else if (valid_q && pitch_output.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_abort_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_rr_q    <= '0;
      s1_ii_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_abort_q <= 1'b0;
      s2_idx_q   <= '0;
      s2_mag_q   <= '0;
      s3_last_q  <= 1'b0;
      max_q      <= '0;
      max_idx_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      s1_valid_q <= fft_output_valid;
      s1_last_q  <= fft_output_valid && (&cnt_q);
      s1_abort_q <= !fft_output_valid && (cnt_q != '0);
      s1_idx_q   <= cnt_q;
      s1_rr_q    <= s1_rr_d;
      s1_ii_q    <= s1_ii_d;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_abort_q <= s1_abort_q;
      s2_idx_q   <= s1_idx_q;
      s2_mag_q   <= s2_mag_d;
      s3_last_q  <= s2_last_q;
      max_q      <= max_d;
      max_idx_q  <= max_idx_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      abort_q    <= s2_abort_q;
    end
  end

  assign pitch_output.data  = data_q;
  assign pitch_output.valid = valid_q;
  assign overflow           = overflow_q;
  assign abort              = abort_q;

endmodule

// File: tb/tb_fft_pitch_detector.sv
// Directed frames with hand-placed peaks; outputs sampled on the falling edge.
module tb_fft_pitch_detector;
  localparam int NS = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [15:0] re_in = '0;
  logic signed [15:0] im_in = '0;
  logic vin = 1'b0;
  logic ovf, abrt, ovf_th, abrt_th;

  fft_pitch_detector_if #(.N(10)) pv ();
  fft_pitch_detector_if #(.N(10)) pv_th ();

  always #5 clk = ~clk;

  fft_pitch_detector #(.W(16), .NSamples(NS)) dut (
    .clk(clk), .reset(rst_n), .fft_output_re(re_in), .fft_output_im(im_in),
    .fft_output_valid(vin), .pitch_output(pv), .overflow(ovf), .abort(abrt)
  );

  fft_pitch_detector #(.W(16), .NSamples(NS), .THRESHOLD(33'd10000)) dut_th (
    .clk(clk), .reset(rst_n), .fft_output_re(re_in), .fft_output_im(im_in),
    .fft_output_valid(vin), .pitch_output(pv_th), .overflow(ovf_th), .abort(abrt_th)
  );

  assign pv_th.ready = 1'b1;

  logic signed [15:0] re_a [NS];
  logic signed [15:0] im_a [NS];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_valid, n_xfer, n_ovf, n_abort, first_valid, abort_cyc, last_data;
  int th_n_valid, th_data;
  int last_edge, fall_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pv.valid === 1'b1) begin
      n_valid++;
      last_data = int'(pv.data);
      if (first_valid < 0) first_valid = cyc;
      if (pv.ready === 1'b1) n_xfer++;
    end
    if (ovf === 1'b1) n_ovf++;
    if (abrt === 1'b1) begin
      n_abort++;
      abort_cyc = cyc;
    end
    if (pv_th.valid === 1'b1) begin
      th_n_valid++;
      th_data = int'(pv_th.data);
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic mon_clear();
    n_valid = 0; n_xfer = 0; n_ovf = 0; n_abort = 0;
    first_valid = -1; abort_cyc = -1; last_data = -1;
    th_n_valid = 0; th_data = -1;
  endtask

  task automatic clear_bins();
    for (int i = 0; i < NS; i++) begin
      re_a[i] = '0;
      im_a[i] = '0;
    end
  endtask

  task automatic send_frame(input int nbins, input bit drop);
    for (int k = 0; k < nbins; k++) begin
      @(posedge clk); #1;
      vin   = 1'b1;
      re_in = re_a[k % NS];
      im_in = im_a[k % NS];
    end
    last_edge = cyc + 1;
    if (drop) begin
      @(posedge clk); #1;
      vin = 1'b0; re_in = '0; im_in = '0;
      fall_cyc = cyc;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    mon_clear();
    clear_bins();
    pv.ready = 1'b1;
    wait_cyc(3);
    check("rst_valid", 64'(pv.valid), 64'd0);
    check("rst_data", 64'(pv.data), 64'd0);
    check("rst_overflow", 64'(ovf), 64'd0);
    check("rst_abort", 64'(abrt), 64'd0);
    rst_n = 1'b1;
    wait_cyc(2);

    // Single tone
    mon_clear(); clear_bins(); re_a[100] = 16'sd1000;
    send_frame(NS, 1'b1); wait_cyc(6);
    check("tone_data", 64'(last_data), 64'd100);
    check("tone_valid_cycles", 64'(n_valid), 64'd1);
    check("tone_latency", 64'(first_valid), 64'(last_edge + 3));
    check("tone_no_abort", 64'(n_abort), 64'd0);
    check("tone_no_ovf", 64'(n_ovf), 64'd0);

    // Tie keeps lower index
    mon_clear(); clear_bins(); im_a[50] = 16'sd500; im_a[200] = 16'sd500;
    send_frame(NS, 1'b1); wait_cyc(6);
    check("tie_data", 64'(last_data), 64'd50);

    // DC and upper-half bins ignored
    mon_clear(); re_a[0] = 16'sd32767; re_a[900] = -16'sd30000;
    send_frame(NS, 1'b1); wait_cyc(6);
    check("ignored_data", 64'(last_data), 64'd50);

    // Negative extremes
    mon_clear(); clear_bins(); re_a[7] = -16'sd32768; im_a[7] = -16'sd32768;
    send_frame(NS, 1'b1); wait_cyc(6);
    check("extreme_data", 64'(last_data), 64'd7);
    check("extreme_no_ovf", 64'(n_ovf), 64'd0);

    // Threshold: 90^2 = 8100 < 10000
    mon_clear(); clear_bins(); re_a[30] = 16'sd90;
    send_frame(NS, 1'b1); wait_cyc(6);
    check("thr_plain_data", 64'(last_data), 64'd30);
    check("thr_data", 64'(th_data), 64'd0);
    check("thr_valid_cycles", 64'(th_n_valid), 64'd1);

    // Backpressure: B overwrites A
    mon_clear(); pv.ready = 1'b0; clear_bins(); re_a[100] = 16'sd1000;
    send_frame(NS, 1'b0);
    clear_bins(); re_a[300] = 16'sd1000;
    send_frame(NS, 1'b1); wait_cyc(6);
    check("bp_valid", 64'(pv.valid), 64'd1);
    check("bp_data", 64'(pv.data), 64'd300);
    check("bp_ovf_pulses", 64'(n_ovf), 64'd1);
    check("bp_no_xfer", 64'(n_xfer), 64'd0);
    pv.ready = 1'b1;
    wait_cyc(1);
    check("bp_valid_drop", 64'(pv.valid), 64'd0);
    wait_cyc(3);
    check("bp_one_xfer", 64'(n_xfer), 64'd1);
    check("bp_last_data", 64'(last_data), 64'd300);

    // Early termination, then a clean frame
    mon_clear(); clear_bins(); re_a[100] = 16'sd2000;
    send_frame(300, 1'b1); wait_cyc(6);
    check("abort_pulses", 64'(n_abort), 64'd1);
    check("abort_timing", 64'(abort_cyc), 64'(fall_cyc + 3));
    check("abort_no_valid", 64'(n_valid), 64'd0);
    mon_clear(); clear_bins(); re_a[64] = 16'sd1000;
    send_frame(NS, 1'b1); wait_cyc(6);
    check("post_abort_data", 64'(last_data), 64'd64);
    check("post_abort_valid", 64'(n_valid), 64'd1);

    // Reset mid-frame
    mon_clear(); clear_bins(); re_a[20] = 16'sd5000;
    send_frame(501, 1'b0);
    rst_n = 1'b0; vin = 1'b0; re_in = '0; im_in = '0;
    wait_cyc(2);
    check("mid_rst_valid", 64'(pv.valid), 64'd0);
    check("mid_rst_data", 64'(pv.data), 64'd0);
    check("mid_rst_ovf", 64'(ovf), 64'd0);
    check("mid_rst_abort", 64'(abrt), 64'd0);
    rst_n = 1'b1;
    mon_clear(); clear_bins(); re_a[12] = 16'sd1000;
    send_frame(NS, 1'b1); wait_cyc(6);
    check("post_rst_data", 64'(last_data), 64'd12);
    check("post_rst_valid", 64'(n_valid), 64'd1);
    check("post_rst_no_abort", 64'(n_abort), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
